argmax_sequencer: RTL and testbench
===================================

# argmax_sequencer

Sequential argmax engine for the classifier output stage. It accepts the NUM_CLASSES fp32 scores of one inference as a valid/ready stream, in class order, and drives a single shared fp32 max-compare stage once per beat to keep a running maximum and its class index. It then presents the winning score and class index on a held valid/ready result port. It sits between the final fully-connected layer and the result/readout logic.

## Interface
- DATAWIDTH, 32, score width; IEEE-754 single precision only
- NUM_CLASSES, 10, scores per inference; legal range 2..16
- IDXW, 4, class-index width; must satisfy 2^IDXW >= NUM_CLASSES
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- start  in  1  single-cycle pulse; begins one inference, honoured only in IDLE
- in_valid  in  1  score beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  DATAWIDTH  score for the current class
- in_last  in  1  producer marks the final beat
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- out_max  out  DATAWIDTH  winning score
- out_index  out  IDXW  winning class index, 0-based
- len_err  out  1  in_last did not coincide with beat NUM_CLASSES-1; valid with out_valid
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, ACCUM and DONE.
- IDLE -> ACCUM on start. This clears the beat counter cnt, the running max, the index and len_err.
- ACCUM accepts a beat when in_valid && in_ready. The first beat (cnt==0) loads unconditionally. Each later beat goes through the compare stage; if it wins, it replaces the incumbent and out_index becomes cnt.
- ACCUM -> DONE on the accepted beat with cnt==NUM_CLASSES-1. In_last is not used to terminate: a count of exactly NUM_CLASSES beats always ends the inference.
- len_err is set when in_last is accepted with cnt!=NUM_CLASSES-1, or when the final beat arrives without in_last. It is sticky until the next start.
- DONE -> IDLE on out_valid && out_ready.
- Compare rule:
  - Map each value to an ordered key: sign 0 gives {1, bits[30:0]}; sign 1 gives ~bits. A larger unsigned key wins.
  - +0 therefore beats -0.
  - On equal keys the incumbent is kept, so the lowest index wins ties.
  - A NaN (exponent 0xFF, mantissa != 0) never replaces the incumbent.
  - Any non-NaN always replaces a NaN incumbent.
  - If all inputs are NaN, the result is class 0's value with index 0.
- start is ignored in ACCUM and DONE.
- in_ready is 0 in IDLE and DONE. Beats offered there are not consumed.

## Timing
- Reset values: in_ready=0, out_valid=0, out_max=0, out_index=0, len_err=0, busy=0; FSM in IDLE.
- The compare stage is combinational between the incumbent register and in_data. The incumbent updates on the same edge that accepts the beat.
- in_ready rises the cycle after start is sampled. It stays 1 throughout ACCUM, so full throughput is one beat per cycle.
- out_valid rises the cycle after the final beat is accepted. Latency from the last beat to out_valid is 1 cycle.
- out_max, out_index and len_err stay stable while out_valid=1 && out_ready=0.
- out_valid falls the cycle after the handshake.
- The earliest accepted next start is the cycle after returning to IDLE. A start in the same cycle as the out handshake is ignored.
- An rst_n assertion mid-inference discards partial state immediately. There is no output pulse, and the FSM resumes in IDLE.

## Structure
- Shared package, argmax_pkg:
  - the state enum (IDLE/ACCUM/DONE)
  - FP32_EXP_MAX = 8'hFF
  - the ordered-key function
  - the is_nan function
- One sub-module, fp32_max_stage: purely combinational. It takes (a, ia, b, ib) and returns (max, imax), with the tie, NaN and zero rules above. The sequencer instantiates it once, with the incumbent on port a.

## Test plan
- Basic argmax. Stream 10 beats, all 0x3F800000 (1.0) except class 6 = 0x40A00000 (5.0), with in_last on beat 9. Required: out_max=0x40A00000, out_index=6, len_err=0, out_valid one cycle after beat 9.
- Ties and zeros:
  - class 2 and class 7 both 0x40400000 (3.0), all others -1.0 (0xBF800000): required out_index=2.
  - class 0 = 0x80000000 (-0) and class 1 = 0x00000000 (+0), rest negative: required out_index=1.
- NaN handling. Class 0 = 0x7FC00000, classes 1..9 = 0xC0000000 (-2.0). Required: out_max=0xC0000000, out_index=1.
- Backpressure and gaps:
  - drop in_valid randomly mid-stream and hold out_ready=0 for 5 cycles;
  - result must stay stable and busy must stay 1;
  - a start pulse during DONE must be ignored.
- Length error. Assert in_last on beat 4 of 10 (max 0x41200000 at class 8). Required: 10 beats still consumed, out_index=8, len_err=1; len_err clears at the next start.
- Reset mid-operation. Drop rst_n after 4 beats. Required: all outputs go to their reset values asynchronously; a fresh 10-beat inference afterwards gives the correct result.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types and fp32 ordering helpers for the argmax sequencer.
// Keys map IEEE-754 bit patterns onto an unsigned order, so a plain compare picks the larger score.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  // Positive values get the top bit set; negative values are inverted so that more negative sorts lower.
  function automatic logic [31:0] fp32_key(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == FP32_EXP_MAX) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/argmax_sequencer_if.sv
// Score stream, result port and control/status of the argmax sequencer.
// Both streams use valid/ready: a transfer happens on a rising edge where valid && ready are both 1,
// the source holds its payload stable while valid=1 && ready=0, and valid never waits on ready.
interface argmax_sequencer_if #(
  parameter int DATAWIDTH = 32,
  parameter int IDXW      = 4
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_max;
  logic [IDXW-1:0]      out_index;
  logic                 len_err;
  logic                 busy;

  modport master (
    output start, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_index, len_err, busy
  );

  modport slave (
    input  start, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_index, len_err, busy
  );
endinterface

// File: rtl/fp32_max_stage.sv
// Combinational fp32 max of (a, ia) and (b, ib); a is the incumbent and wins ties.
// NaN on b never wins, a non-NaN b always beats a NaN incumbent.
module fp32_max_stage
  import argmax_pkg::*;
#(
  parameter int IDXW = 4
) (
  input  logic [31:0]     i_a,
  input  logic [IDXW-1:0] i_ia,
  input  logic [31:0]     i_b,
  input  logic [IDXW-1:0] i_ib,
  output logic [31:0]     o_max,
  output logic [IDXW-1:0] o_imax
);

  logic w_a_nan;
  logic w_b_nan;
  logic w_take_b;

  assign w_a_nan = is_nan(i_a);
  assign w_b_nan = is_nan(i_b);

  always_comb begin
    w_take_b = 1'b0;
    if (w_b_nan) begin
      w_take_b = 1'b0;
    end else if (w_a_nan) begin
      w_take_b = 1'b1;
    end else begin
      // Strictly greater: equal keys keep the incumbent, so the lowest index wins ties.
      w_take_b = fp32_key(i_b) > fp32_key(i_a);
    end
  end

  assign o_max  = w_take_b ? i_b  : i_a;
  assign o_imax = w_take_b ? i_ib : i_ia;

endmodule

// File: rtl/argmax_sequencer.sv
// Sequential argmax over NUM_CLASSES fp32 scores, one beat per cycle through a shared compare stage.
// The winning score/index are held on a valid/ready result port until accepted.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDXW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  argmax_sequencer_if.slave   bus,
  output state_t              dbg_state
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CLASSES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [IDXW-1:0]       r_cnt;
  logic [DATAWIDTH-1:0]  r_max;
  logic [IDXW-1:0]       r_idx;
  logic                  r_len_err;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_busy;
  logic                  w_fire;
  logic                  w_final;
  logic                  w_start_ok;
  logic [DATAWIDTH-1:0]  w_max;
  logic [IDXW-1:0]       w_imax;

  fp32_max_stage #(.IDXW(IDXW)) u_max (
    .i_a    (r_max),
    .i_ia   (r_idx),
    .i_b    (bus.in_data),
    .i_ib   (r_cnt),
    .o_max  (w_max),
    .o_imax (w_imax)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_start_ok  = 1'b0;
    w_fire      = 1'b0;
    w_final     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy     = 1'b0;
        w_start_ok = bus.start;
        if (bus.start) w_next = ACCUM;
      end
      ACCUM: begin
        w_in_ready = 1'b1;
        w_fire     = bus.in_valid;
        w_final    = bus.in_valid && (r_cnt == LAST_IDX);
        if (w_final) w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_len_err <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_len_err <= 1'b0;
    end else if (w_fire) begin
      r_cnt <= w_final ? '0 : r_cnt + 1'b1;
      // The first beat seeds the incumbent, so an all-NaN inference reports class 0.
      if (r_cnt == '0) begin
        r_max <= bus.in_data;
        r_idx <= '0;
      end else begin
        r_max <= w_max;
        r_idx <= w_imax;
      end
      // in_last must coincide exactly with the final counted beat; any other placement is an error.
      if (bus.in_last != w_final) r_len_err <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_max   = r_max;
  assign bus.out_index = r_idx;
  assign bus.len_err   = r_len_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed bench for argmax_sequencer: expected results queued at stimulus time, checked by a monitor.
module tb_argmax_sequencer;
  import argmax_pkg::*;

  localparam int NC = 10;
  localparam int IW = 4;
  localparam int W  = 1 + IW + 32;

  logic clk;
  logic rst_n;
  state_t dbg_state;

  argmax_sequencer_if #(.DATAWIDTH(32), .IDXW(IW)) bus ();

  argmax_sequencer #(.DATAWIDTH(32), .NUM_CLASSES(NC), .IDXW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  vec [NC];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // scoreboard monitor: one pop per result handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      logic [W-1:0] got;
      got = {bus.len_err, bus.out_index, bus.out_max};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %0h required none", got);
      end else begin
        logic [W-1:0] req;
        req = exp_q.pop_front();
        if (got !== req) begin
          n_err++;
          $display("FAIL result: got err=%0b idx=%0d max=%08h required err=%0b idx=%0d max=%08h",
                   got[W-1], got[W-2:32], got[31:0], req[W-1], req[W-2:32], req[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < NC; i++) vec[i] = v;
  endtask

  task automatic expect_result(input logic err, input logic [IW-1:0] idx, input logic [31:0] mx);
    exp_q.push_back({err, idx, mx});
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1);
  endtask

  task automatic send_beats(input int n, input int last_pos, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        check("busy_in_gap", bus.busy, 1);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_last  = (i == last_pos);
      t = 0;
      while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t == 50) check("in_ready_wait", bus.in_ready, 1);
      if (i == NC - 1) check("out_valid_before_last", bus.out_valid, 0);
      @(posedge clk); #1;
      if (i == NC - 1) check("out_valid_latency", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain_result();
    int t;
    t = 0;
    while (bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("out_valid_falls", bus.out_valid, 0);
    check("busy_after_done", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_max",   bus.out_max, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_len_err",   bus.len_err, 0);
    check("rst_busy",      bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic argmax: 5.0 at class 6
    fill(32'h3F800000); vec[6] = 32'h40A00000;
    expect_result(1'b0, 4'd6, 32'h40A00000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    // tie: 3.0 at classes 2 and 7
    fill(32'hBF800000); vec[2] = 32'h40400000; vec[7] = 32'h40400000;
    expect_result(1'b0, 4'd2, 32'h40400000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    // +0 beats -0
    fill(32'hBF800000); vec[0] = 32'h80000000; vec[1] = 32'h00000000;
    expect_result(1'b0, 4'd1, 32'h00000000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    // NaN incumbent replaced, then ties keep class 1
    fill(32'hC0000000); vec[0] = 32'h7FC00000;
    expect_result(1'b0, 4'd1, 32'hC0000000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    // all NaN: class 0 kept
    fill(32'h7FC00001); vec[0] = 32'hFFC00000;
    expect_result(1'b0, 4'd0, 32'hFFC00000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    // backpressure and gaps: 100.0 at class 3
    for (int i = 0; i < NC; i++) vec[i] = 32'h3F800000 + (i << 20);
    vec[3] = 32'h42C80000;
    expect_result(1'b0, 4'd3, 32'h42C80000);
    bus.out_ready = 1'b0;
    do_start(); send_beats(NC, NC - 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_busy",      bus.busy, 1);
      check("hold_in_ready",  bus.in_ready, 0);
      check("hold_out_max",   bus.out_max, 32'h42C80000);
      check("hold_out_index", bus.out_index, 3);
      bus.start = (c == 2);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    // start coinciding with the handshake must be ignored
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("hs_out_valid_low", bus.out_valid, 0);
    check("hs_start_ignored", bus.busy, 0);

    // length error: in_last on beat 4, 10.0 at class 8
    fill(32'h3F800000); vec[8] = 32'h41200000;
    expect_result(1'b1, 4'd8, 32'h41200000);
    do_start(); send_beats(NC, 4, 1'b0); drain_result();
    check("len_err_sticky_idle", bus.len_err, 1);
    fill(32'h3F800000); vec[9] = 32'h40000000;
    expect_result(1'b0, 4'd9, 32'h40000000);
    do_start();
    check("len_err_cleared", bus.len_err, 0);
    send_beats(NC, NC - 1, 1'b0); drain_result();

    // reset mid-inference after 4 beats
    fill(32'h40800000);
    do_start(); send_beats(4, -1, 1'b0);
    check("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  bus.in_ready, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_max",   bus.out_max, 0);
    check("arst_out_index", bus.out_index, 0);
    check("arst_busy",      bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    fill(32'hC1000000); vec[5] = 32'h3E800000;
    expect_result(1'b0, 4'd5, 32'h3E800000);
    do_start(); send_beats(NC, NC - 1, 1'b0); drain_result();

    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin @(posedge clk); t++; end
      check("queue_drained", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
